// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK counter controller: cell drive codes, command
// opcodes and FSM states.
package jk_ctrl_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // J/K pair that forces a cell to the given value on the next edge.
  function automatic logic [1:0] jk_drive(input logic bit_val);
    return bit_val ? JK_SET : JK_RST;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low reset to 0.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] jk,
  output logic       q
);

  // JK state update: hold / reset / set / toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case (jk)
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command-driven sequencer that loads, clears or steps a bank of JK cells
// up/down a programmed number of times, reporting busy/done/wrap.
module jk_counter_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_e                  state_r;
  state_e                  next_state_s;
  logic [LEN_W-1:0]        remaining_r;
  logic [1:0]              op_r;
  logic [WIDTH-1:0]        data_r;
  logic [WIDTH-1:0][1:0]   jk_s;
  logic [WIDTH-1:0]        tog_s;
  logic                    accept_s;
  logic                    step_s;
  logic                    up_s;
  logic                    wrap_s;
  logic                    busy_s;
  logic                    done_s;
  logic                    ready_s;
  logic                    busy_r;
  logic                    done_r;
  logic                    ready_r;
  logic                    wrap_r;

  assign accept_s = cmd_valid && (state_r == ST_IDLE);
  assign step_s   = (state_r == ST_RUN) && !abort;
  assign up_s     = (op_r == OP_UP);
  assign wrap_s   = step_s && (up_s ? (&q) : ~(|q));

  // State register plus registered status outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ready_r <= ready_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          next_state_s = ST_IDLE;
        end else if (cmd_op == OP_LOAD || cmd_op == OP_CLEAR) begin
          next_state_s = ST_LOAD;
        end else if (cmd_len == {LEN_W{1'b0}}) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LOAD: next_state_s = ST_DONE;
      ST_RUN: begin
        if (abort) begin
          next_state_s = ST_DONE;
        end else if (remaining_r == LEN_W'(1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Status outputs for the state being entered.
  always_comb begin
    busy_s  = 1'b0;
    done_s  = 1'b0;
    ready_s = 1'b0;
    case (next_state_s)
      ST_IDLE: ready_s = 1'b1;
      ST_LOAD: busy_s  = 1'b1;
      ST_RUN:  busy_s  = 1'b1;
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: ready_s = 1'b1;
    endcase
  end

  // Command latch, step counter and wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r        <= OP_LOAD;
      data_r      <= {WIDTH{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
      wrap_r      <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
      if (accept_s) begin
        op_r        <= cmd_op;
        // CLEAR is a load of zero, so the LOAD state handles both.
        data_r      <= (cmd_op == OP_CLEAR) ? {WIDTH{1'b0}} : cmd_data;
        remaining_r <= cmd_len;
      end else if (step_s) begin
        remaining_r <= remaining_r - LEN_W'(1);
      end else if (state_r == ST_RUN) begin
        remaining_r <= {LEN_W{1'b0}};
      end else begin
        remaining_r <= remaining_r;
      end
    end
  end

  // Per-bit J/K generation: forced load, or ripple-toggle for counting.
  always_comb begin
    tog_s    = {WIDTH{1'b0}};
    tog_s[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      tog_s[i] = tog_s[i-1] & (up_s ? q[i-1] : ~q[i-1]);
    end
    jk_s = '{default: JK_HOLD};
    case (state_r)
      ST_LOAD: begin
        for (int i = 0; i < WIDTH; i++) begin
          jk_s[i] = jk_drive(data_r[i]);
        end
      end
      ST_RUN: begin
        for (int i = 0; i < WIDTH; i++) begin
          jk_s[i] = (step_s && tog_s[i]) ? JK_TOG : JK_HOLD;
        end
      end
      default: jk_s = '{default: JK_HOLD};
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .jk    (jk_s[g]),
      .q     (q[g])
    );
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign wrap      = wrap_r;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Self-checking bench for jk_counter_ctrl: directed table, corner sequences
// and random commands checked cycle by cycle against an arithmetic model.
module tb_jk_counter_ctrl;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;
  localparam int MASK  = (1 << WIDTH) - 1;

  localparam logic [1:0] T_LOAD  = 2'b00;
  localparam logic [1:0] T_UP    = 2'b01;
  localparam logic [1:0] T_DOWN  = 2'b10;
  localparam logic [1:0] T_CLEAR = 2'b11;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             wrap;

  jk_counter_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    int         data;
    int         len;
    int         abort_at;
    int         exp_q;
    int         exp_busy;
    int         exp_wraps;
  } vec_t;

  vec_t tbl[11];
  int   n_tests;
  int   n_fail;
  int   mq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit step_wraps(input bit up, input int old, input int k);
    if (up) return ((old + k - 1) & MASK) == MASK;
    else    return ((old - k + 1) & MASK) == 0;
  endfunction

  // Issue one command from IDLE and check every cycle until back in IDLE.
  task automatic run_cmd(input logic [1:0] op, input int data, input int len,
                         input int abort_at, input bit hold,
                         output int busy_cnt, output int wraps);
    int old, stop, end_n, fin, eq;
    bit is_load, up, eb, ed, ew, er;
    logic [WIDTH-1:0] eqv;
    old     = mq;
    is_load = (op == T_LOAD) || (op == T_CLEAR);
    up      = (op == T_UP);
    stop    = 0;
    if (is_load) begin
      end_n = 1;
      fin   = (op == T_CLEAR) ? 0 : (data & MASK);
    end else begin
      if (len == 0) begin
        end_n = 0;
      end else if (abort_at >= 0) begin
        stop  = abort_at;
        end_n = abort_at + 1;
      end else begin
        stop  = len;
        end_n = len;
      end
      fin = up ? ((old + stop) & MASK) : ((old - stop) & MASK);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data[WIDTH-1:0];
    cmd_len   = len[LEN_W-1:0];
    check("ready_at_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = WIDTH'($urandom);
      cmd_len   = LEN_W'($urandom);
    end
    busy_cnt = 0;
    wraps    = 0;
    for (int n = 0; n <= end_n + 1; n++) begin
      if (n > end_n) begin
        eq = fin; eb = 1'b0; ed = 1'b0; ew = 1'b0; er = 1'b1;
      end else if (n == end_n) begin
        eq = fin; eb = 1'b1; ed = 1'b1; er = 1'b0;
        ew = (!is_load && len > 0 && abort_at < 0) ? step_wraps(up, old, n) : 1'b0;
      end else begin
        eq = is_load ? old : (up ? ((old + n) & MASK) : ((old - n) & MASK));
        eb = 1'b1; ed = 1'b0; er = 1'b0;
        ew = (!is_load && n >= 1) ? step_wraps(up, old, n) : 1'b0;
      end
      eqv = eq[WIDTH-1:0];
      check($sformatf("cyc%0d{q,busy,done,wrap,rdy}", n),
            {24'd0, q, busy, done, wrap, cmd_ready},
            {24'd0, eqv, eb, ed, ew, er});
      if (busy) busy_cnt++;
      if (wrap) wraps++;
      if (n <= end_n) begin
        abort = (n == abort_at);
        @(negedge clk);
      end
    end
    abort = 1'b0;
    mq    = fin;
  endtask

  initial begin
    int bc, wc, op_i, data_i, len_i, ab_i;
    n_tests = 0;
    n_fail  = 0;
    mq      = 0;

    tbl[0]  = '{T_LOAD,  4'b1010, 0,   -1, 4'b1010, 2,  0};
    tbl[1]  = '{T_LOAD,  4'b1101, 0,   -1, 4'b1101, 2,  0};
    tbl[2]  = '{T_UP,    0,       5,   -1, 4'b0010, 6,  1};
    tbl[3]  = '{T_LOAD,  4'b0001, 0,   -1, 4'b0001, 2,  0};
    tbl[4]  = '{T_DOWN,  0,       3,   -1, 4'b1110, 4,  1};
    tbl[5]  = '{T_CLEAR, 4'b1111, 0,   -1, 4'b0000, 2,  0};
    tbl[6]  = '{T_UP,    0,       0,   -1, 4'b0000, 1,  0};
    tbl[7]  = '{T_UP,    0,       200, 10, 4'b1010, 12, 0};
    tbl[8]  = '{T_DOWN,  0,       20,  -1, 4'b0110, 21, 1};
    tbl[9]  = '{T_LOAD,  4'b1111, 0,   -1, 4'b1111, 2,  0};
    tbl[10] = '{T_UP,    0,       1,   -1, 4'b0000, 2,  1};

    // Reset held with a command waiting: nothing may be accepted.
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = T_UP;
    cmd_data  = 4'b0000;
    cmd_len   = 8'd5;
    abort     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_q", {28'd0, q}, 32'd0);
    check("reset_busy_done_wrap", {29'd0, busy, done, wrap}, 32'd0);
    cmd_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_cmd(tbl[i].op, tbl[i].data, tbl[i].len, tbl[i].abort_at, 1'b0, bc, wc);
      check($sformatf("tbl%0d_q", i), {28'd0, q}, tbl[i].exp_q);
      check($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].exp_busy);
      check($sformatf("tbl%0d_wraps", i), wc, tbl[i].exp_wraps);
    end

    // cmd_valid held high: DONE must not accept, next IDLE does.
    run_cmd(T_LOAD, 4'b0011, 0, -1, 1'b1, bc, wc);
    run_cmd(T_LOAD, 4'b0011, 0, -1, 1'b1, bc, wc);
    cmd_valid = 1'b0;
    check("hold_valid_q", {28'd0, q}, 32'd3);

    // Asynchronous reset in the middle of a run.
    cmd_valid = 1'b1;
    cmd_op    = T_UP;
    cmd_len   = 8'd50;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_q_before_reset", {28'd0, q}, (mq + 4) & MASK);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_q", {28'd0, q}, 32'd0);
    check("midrun_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mq    = 0;
    @(negedge clk);
    run_cmd(T_UP, 0, 3, -1, 1'b0, bc, wc);
    check("after_reset_up3_q", {28'd0, q}, 32'd3);

    // Random commands against the model.
    for (int r = 0; r < 40; r++) begin
      op_i   = $urandom_range(0, 3);
      data_i = $urandom_range(0, MASK);
      len_i  = $urandom_range(0, 20);
      ab_i   = -1;
      if (op_i == 0 || op_i == 3) begin
        ab_i = $urandom_range(0, 1);
      end else if (len_i > 0 && $urandom_range(0, 3) == 0) begin
        ab_i = $urandom_range(0, len_i - 1);
      end
      run_cmd(op_i[1:0], data_i, len_i, ab_i, 1'b0, bc, wc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
